// File: rtl/calc1.sv
// Four-port integer calculator: each requester runs its own command/operand
// sequencer and gets a one-cycle registered response two edges after its command.
module calc1 (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_EXEC} state_e;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  logic        rst;
  logic [3:0]  cmd_in   [4];
  logic [31:0] data_in  [4];
  logic [31:0] data_out [4];
  logic [1:0]  resp_out [4];

  assign rst = |reset;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_data1 = data_out[0];
  assign out_resp1 = resp_out[0];
  assign out_data2 = data_out[1];
  assign out_resp2 = resp_out[1];
  assign out_data3 = data_out[2];
  assign out_resp3 = resp_out[2];
  assign out_data4 = data_out[3];
  assign out_resp4 = resp_out[3];

  // Request protocol: a nonzero cmd with op1 is taken whenever the port is in
  // IDLE or EXEC; the bus always carries op2 on the very next cycle (cmd ignored
  // then); the response is a single-cycle pulse, there is no backpressure.
  for (genvar p = 0; p < 4; p++) begin : g_port
    state_e      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  resp_q, resp_d;
    logic [32:0] sum;
    logic [31:0] exec_data;
    logic [1:0]  exec_resp;

    always_comb begin
      sum       = {1'b0, op1_q} + {1'b0, op2_q};
      exec_data = '0;
      exec_resp = RESP_ERR;
      case (cmd_q)
        CMD_ADD: if (!sum[32]) begin
          exec_resp = RESP_OK;
          exec_data = sum[31:0];
        end
        CMD_SUB: if (op2_q <= op1_q) begin
          exec_resp = RESP_OK;
          exec_data = op1_q - op2_q;
        end
        CMD_SHL: begin
          exec_resp = RESP_OK;
          exec_data = op1_q << op2_q[4:0];
        end
        CMD_SHR: begin
          exec_resp = RESP_OK;
          exec_data = op1_q >> op2_q[4:0];
        end
        default: ;
      endcase
    end

    always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      resp_d  = RESP_NONE;
      data_d  = '0;
      case (state_q)
        ST_IDLE: if (cmd_in[p] != CMD_NOP) begin
          cmd_d   = cmd_in[p];
          op1_d   = data_in[p];
          state_d = ST_OP2;
        end
        ST_OP2: begin
          op2_d   = data_in[p];
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          resp_d = exec_resp;
          data_d = exec_data;
          // Accepting here is what lets a port sustain one op every two cycles.
          if (cmd_in[p] != CMD_NOP) begin
            cmd_d   = cmd_in[p];
            op1_d   = data_in[p];
            state_d = ST_OP2;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        cmd_q   <= '0;
        op1_q   <= '0;
        op2_q   <= '0;
        resp_q  <= RESP_NONE;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        cmd_q   <= cmd_d;
        op1_q   <= op1_d;
        op2_q   <= op2_d;
        resp_q  <= resp_d;
        data_q  <= data_d;
      end
    end

    assign data_out[p] = data_q;
    assign resp_out[p] = resp_q;
  end

endmodule

// File: tb/tb_calc1.sv
// Directed bench for calc1: table of single-port vectors rotated over the four
// ports, an add sweep, plus hand-written concurrency, pipelining and reset cases.
module tb_calc1;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] SHL = 4'd5;
  localparam logic [3:0] SHR = 4'd6;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  drv_cmd  [4];
  logic [31:0] drv_data [4];
  logic [0:31] out_data1, out_data2, out_data3, out_data4;
  logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [31:0] dout [4];
  logic [1:0]  rout [4];

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  always #5 c_clk = ~c_clk;

  calc1 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (drv_cmd[0]),
    .req1_data_in (drv_data[0]),
    .req2_cmd_in  (drv_cmd[1]),
    .req2_data_in (drv_data[1]),
    .req3_cmd_in  (drv_cmd[2]),
    .req3_data_in (drv_data[2]),
    .req4_cmd_in  (drv_cmd[3]),
    .req4_data_in (drv_data[3]),
    .out_data1    (out_data1),
    .out_resp1    (out_resp1),
    .out_data2    (out_data2),
    .out_resp2    (out_resp2),
    .out_data3    (out_data3),
    .out_resp3    (out_resp3),
    .out_data4    (out_data4),
    .out_resp4    (out_resp4)
  );

  assign dout[0] = out_data1;
  assign dout[1] = out_data2;
  assign dout[2] = out_data3;
  assign dout[3] = out_data4;
  assign rout[0] = out_resp1;
  assign rout[1] = out_resp2;
  assign rout[2] = out_resp3;
  assign rout[3] = out_resp4;

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] r, input logic [31:0] d);
    vec_t v;
    v.cmd = c; v.op1 = a; v.op2 = b; v.exp_resp = r; v.exp_data = d;
    return v;
  endfunction

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_port(input string tag, input int p, input logic [1:0] er, input logic [31:0] ed);
    check($sformatf("%s p%0d resp", tag, p + 1), {30'd0, rout[p]}, {30'd0, er});
    check($sformatf("%s p%0d data", tag, p + 1), dout[p], ed);
  endtask

  task automatic check_idle(input string tag, input int except);
    for (int p = 0; p < 4; p++)
      if (p != except) check_port(tag, p, 2'd0, 32'd0);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) begin
      drv_cmd[p]  = '0;
      drv_data[p] = '0;
    end
  endtask

  task automatic run_vec(input string tag, input int p, input vec_t v);
    drv_cmd[p] = v.cmd; drv_data[p] = v.op1;
    step();
    drv_cmd[p] = '0; drv_data[p] = v.op2;
    step();
    check_port({tag, " E1"}, p, 2'd0, 32'd0);
    drv_data[p] = '0;
    step();
    check_port(tag, p, v.exp_resp, v.exp_data);
    check_idle({tag, " other"}, p);
    step();
    check_port({tag, " after"}, p, 2'd0, 32'd0);
  endtask

  initial begin
    vecs.push_back(mk(ADD,  32'h1,         32'h1FFF_FFFF, 2'd1, 32'h2000_0000));
    vecs.push_back(mk(ADD,  32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE));
    vecs.push_back(mk(ADD,  32'h0,         32'h0,         2'd1, 32'h0));
    vecs.push_back(mk(ADD,  32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0));
    vecs.push_back(mk(ADD,  32'hFFFF_FFFF, 32'h0,         2'd1, 32'hFFFF_FFFF));
    vecs.push_back(mk(SUB,  32'h1,         32'hF,         2'd2, 32'h0));
    vecs.push_back(mk(SUB,  32'hF,         32'h1,         2'd1, 32'hE));
    vecs.push_back(mk(SUB,  32'h1234,      32'h1234,      2'd1, 32'h0));
    vecs.push_back(mk(SHL,  32'h1,         32'd31,        2'd1, 32'h8000_0000));
    vecs.push_back(mk(SHR,  32'h8000_0000, 32'h21,        2'd1, 32'h4000_0000));
    vecs.push_back(mk(SHL,  32'hABCD,      32'h0,         2'd1, 32'hABCD));
    vecs.push_back(mk(SHR,  32'hABCD,      32'h20,        2'd1, 32'hABCD));
    vecs.push_back(mk(SHL,  32'hF000_0001, 32'd4,         2'd1, 32'h0000_0010));
    vecs.push_back(mk(4'd3, 32'h1,         32'h1,         2'd2, 32'h0));
    vecs.push_back(mk(4'd4, 32'h1,         32'h1,         2'd2, 32'h0));
    vecs.push_back(mk(4'd15,32'h1,         32'h1,         2'd2, 32'h0));
    vecs.push_back(mk(4'd7, 32'h1,         32'h1,         2'd2, 32'h0));
    vecs.push_back(mk(4'd0, 32'h5,         32'h5,         2'd0, 32'h0));

    // Reset: any bit of the bus resets; bit 1 is the normal driver.
    clear_inputs();
    reset = '0;
    reset[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("in reset", -1);
    end
    reset = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("post reset", -1);
    end

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), i % 4, vecs[i]);

    for (int x = 0; x < 15; x++)
      for (int y = 0; y < 15; y++)
        run_vec($sformatf("sweep %0d+%0d", x, y), 0,
                mk(ADD, 32'(x), 32'(y), 2'd1, 32'(x + y)));

    // All four ports at once.
    drv_cmd[0] = ADD; drv_data[0] = 32'd5;
    drv_cmd[1] = SUB; drv_data[1] = 32'd100;
    drv_cmd[2] = SHL; drv_data[2] = 32'h3;
    drv_cmd[3] = SHR; drv_data[3] = 32'hF0;
    step();
    drv_cmd[0] = '0; drv_data[0] = 32'd7;
    drv_cmd[1] = '0; drv_data[1] = 32'd1;
    drv_cmd[2] = '0; drv_data[2] = 32'd4;
    drv_cmd[3] = '0; drv_data[3] = 32'd4;
    step();
    check_idle("conc E1", -1);
    clear_inputs();
    step();
    check_port("conc", 0, 2'd1, 32'd12);
    check_port("conc", 1, 2'd1, 32'd99);
    check_port("conc", 2, 2'd1, 32'h30);
    check_port("conc", 3, 2'd1, 32'hF);
    step();
    check_idle("conc after", -1);

    // Back-to-back on port 2: second command presented during EXEC.
    drv_cmd[1] = SUB; drv_data[1] = 32'h10;
    step();
    drv_cmd[1] = '0;  drv_data[1] = 32'h3;
    step();
    drv_cmd[1] = SHL; drv_data[1] = 32'hFF;
    step();
    check_port("b2b A", 1, 2'd1, 32'hD);
    drv_cmd[1] = '0;  drv_data[1] = 32'd8;
    step();
    check_port("b2b gap", 1, 2'd0, 32'h0);
    drv_data[1] = '0;
    step();
    check_port("b2b B", 1, 2'd1, 32'hFF00);
    step();
    check_idle("b2b after", -1);

    // Reset pulse (bit 3) while port 3 is in OP2.
    drv_cmd[2] = ADD; drv_data[2] = 32'h1;
    step();
    drv_cmd[2] = '0;
    reset[3] = 1'b1;
    #2;
    reset = '0;
    drv_data[2] = 32'h1;
    for (int i = 0; i < 4; i++) begin
      step();
      drv_data[2] = '0;
      check_idle("rst op2", -1);
    end

    // Reset pulse (bit 7) while port 4 is in EXEC.
    drv_cmd[3] = SUB; drv_data[3] = 32'h9;
    step();
    drv_cmd[3] = '0; drv_data[3] = 32'h2;
    step();
    drv_data[3] = '0;
    reset[7] = 1'b1;
    #2;
    reset = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst exec", -1);
    end

    // Reset while a response is visible clears it immediately.
    drv_cmd[0] = ADD; drv_data[0] = 32'h2;
    step();
    drv_cmd[0] = '0; drv_data[0] = 32'h3;
    step();
    drv_data[0] = '0;
    step();
    check_port("pre rst resp", 0, 2'd1, 32'h5);
    reset[1] = 1'b1;
    #1;
    check_idle("rst resp", -1);
    step();
    reset = '0;
    step();
    check_idle("rst resp after", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
